// File: rtl/csr_timer_bank.sv
// NUM_TIMERS TCFG/TVAL/TICLR timer channels with prescaler and sticky pending bits, plus a 64-bit stable counter.
// Latency: reads are combinational, writes and counting take effect next cycle; no backpressure.
module csr_timer_bank #(
    parameter int          NUM_TIMERS = 2,
    parameter int          CNT_WIDTH  = 32,
    parameter int          PRESCALE   = 1,
    parameter logic [13:0] BASE_ADDR  = 14'h041
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [13:0]           csr_num,
    input  logic                  csr_we,
    input  logic [31:0]           csr_wmask,
    input  logic [31:0]           csr_wvalue,
    output logic [31:0]           csr_rvalue,
    output logic                  csr_hit,
    output logic [NUM_TIMERS-1:0] timer_int,
    output logic [63:0]           stable_cnt
);
    localparam int                   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int                   IW       = CNT_WIDTH - 2;
    localparam logic [CNT_WIDTH-1:0] ALL1     = '1;
    localparam logic [PW-1:0]        PRE_LAST = PW'(PRESCALE - 1);

    logic [NUM_TIMERS-1:0] en_q;
    logic [NUM_TIMERS-1:0] per_q;
    logic [NUM_TIMERS-1:0] pend_q;
    logic [IW-1:0]         init_q [NUM_TIMERS];
    logic [CNT_WIDTH-1:0]  cnt_q  [NUM_TIMERS];
    logic [PW-1:0]         pre_q  [NUM_TIMERS];
    logic [63:0]           stable_q;

    logic [NUM_TIMERS-1:0] sel_cfg;
    logic [NUM_TIMERS-1:0] sel_val;
    logic [NUM_TIMERS-1:0] sel_clr;
    logic [NUM_TIMERS-1:0] wr_cfg;
    logic [NUM_TIMERS-1:0] clr;
    logic [NUM_TIMERS-1:0] tick;
    logic [NUM_TIMERS-1:0] zero_tick;
    logic [31:0]           cfg_rd  [NUM_TIMERS];
    logic [31:0]           cfg_new [NUM_TIMERS];
    logic [CNT_WIDTH-1:0]  reload  [NUM_TIMERS];

    always_comb begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
            sel_cfg[i]   = (csr_num == BASE_ADDR + 14'(4 * i));
            sel_val[i]   = (csr_num == BASE_ADDR + 14'(4 * i + 1));
            sel_clr[i]   = (csr_num == BASE_ADDR + 14'(4 * i + 3));
            cfg_rd[i]    = 32'({init_q[i], per_q[i], en_q[i]});
            cfg_new[i]   = (csr_wmask & csr_wvalue) | (~csr_wmask & cfg_rd[i]);
            wr_cfg[i]    = csr_we && sel_cfg[i];
            clr[i]       = csr_we && sel_clr[i] && csr_wmask[0] && csr_wvalue[0];
            reload[i]    = {init_q[i], 2'b00};
            tick[i]      = en_q[i] && (pre_q[i] == PRE_LAST);
            // A TCFG write in the same cycle wins over the count, including its zero tick
            zero_tick[i] = tick[i] && !wr_cfg[i] && (cnt_q[i] == '0);
        end
    end

    always_comb begin
        csr_hit    = 1'b0;
        csr_rvalue = 32'd0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (sel_cfg[i]) begin
                csr_hit    = 1'b1;
                csr_rvalue = cfg_rd[i];
            end
            if (sel_val[i]) begin
                csr_hit    = 1'b1;
                csr_rvalue = 32'(cnt_q[i]);
            end
            if (sel_clr[i]) begin
                csr_hit    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            en_q     <= '0;
            per_q    <= '0;
            pend_q   <= '0;
            stable_q <= 64'd0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                init_q[i] <= '0;
                cnt_q[i]  <= ALL1;
                pre_q[i]  <= '0;
            end
        end else begin
            stable_q <= stable_q + 64'd1;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (wr_cfg[i]) begin
                    en_q[i]   <= cfg_new[i][0];
                    per_q[i]  <= cfg_new[i][1];
                    init_q[i] <= cfg_new[i][CNT_WIDTH-1:2];
                    if (cfg_new[i][0]) begin
                        cnt_q[i] <= {cfg_new[i][CNT_WIDTH-1:2], 2'b00};
                        pre_q[i] <= '0;
                    end
                end else if (en_q[i]) begin
                    pre_q[i] <= (pre_q[i] == PRE_LAST) ? '0 : pre_q[i] + PW'(1);
                    if (tick[i]) begin
                        // An expired one-shot parks at all-ones and stays there
                        if (cnt_q[i] == '0)
                            cnt_q[i] <= per_q[i] ? reload[i] : ALL1;
                        else if (cnt_q[i] != ALL1 || per_q[i])
                            cnt_q[i] <= cnt_q[i] - CNT_WIDTH'(1);
                    end
                end
                if (zero_tick[i])
                    pend_q[i] <= 1'b1;
                else if (clr[i])
                    pend_q[i] <= 1'b0;
            end
        end
    end

    assign timer_int  = pend_q;
    assign stable_cnt = stable_q;
endmodule

// File: tb/tb_csr_timer_bank.sv
// Bench for csr_timer_bank: two instances (PRESCALE 1 and 4) on a shared CSR bus,
// checked every cycle against an elapsed-time model plus directed sequences.
module tb_csr_timer_bank;
    localparam int          NT   = 2;
    localparam logic [13:0] BASE = 14'h041;
    localparam longint      ALL1 = 64'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [13:0]   csr_num = 14'd0;
    logic          csr_we = 1'b0;
    logic [31:0]   csr_wmask = 32'd0;
    logic [31:0]   csr_wvalue = 32'd0;
    logic [31:0]   rv1, rv4;
    logic          hit1, hit4;
    logic [NT-1:0] int1, int4;
    logic [63:0]   scnt1, scnt4;

    int vectors = 0;
    int miscompares = 0;

    csr_timer_bank #(.NUM_TIMERS(NT), .CNT_WIDTH(32), .PRESCALE(1), .BASE_ADDR(BASE)) dut (
        .clk(clk), .resetn(resetn), .csr_num(csr_num), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(rv1),
        .csr_hit(hit1), .timer_int(int1), .stable_cnt(scnt1));

    csr_timer_bank #(.NUM_TIMERS(NT), .CNT_WIDTH(32), .PRESCALE(4), .BASE_ADDR(BASE)) dut4 (
        .clk(clk), .resetn(resetn), .csr_num(csr_num), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(rv4),
        .csr_hit(hit4), .timer_int(int4), .stable_cnt(scnt4));

    always #5 clk = ~clk;

    // Model: each channel remembers the edge it was last started on; the count and
    // the zero-tick edges follow from elapsed time by plain arithmetic.
    int          pscale [2] = '{1, 4};
    logic [31:0] m_tcfg [2][NT];
    bit          m_run  [2][NT];
    longint      m_t0   [2][NT];
    longint      m_frz  [2][NT];
    bit          m_pend [2][NT];
    longint      edge_n = 0;
    longint      rst_edge = 0;

    function automatic longint m_reload(int j, int i);
        return longint'(m_tcfg[j][i] & 32'hFFFF_FFFC);
    endfunction

    function automatic longint m_cnt(int j, int i, longint e);
        longint r, n;
        if (!m_run[j][i]) return m_frz[j][i];
        r = m_reload(j, i);
        n = (e - m_t0[j][i]) / pscale[j];
        if (m_tcfg[j][i][1]) return r - (n % (r + 1));
        return (n <= r) ? r - n : ALL1;
    endfunction

    function automatic bit m_zero_tick(int j, int i, longint e);
        longint k, p;
        if (!m_run[j][i]) return 1'b0;
        k = e - m_t0[j][i];
        p = (m_reload(j, i) + 1) * pscale[j];
        if (k <= 0) return 1'b0;
        if (m_tcfg[j][i][1]) return (k % p) == 0;
        return k == p;
    endfunction

    task automatic model_edge();
        logic [31:0] nv;
        bit          wr, cl;
        edge_n++;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < NT; i++) begin
                if (!resetn) begin
                    m_tcfg[j][i] = 32'd0;
                    m_run[j][i]  = 1'b0;
                    m_frz[j][i]  = ALL1;
                    m_pend[j][i] = 1'b0;
                end else begin
                    wr = csr_we && (csr_num == BASE + 14'(4 * i));
                    cl = csr_we && (csr_num == BASE + 14'(4 * i + 3)) && csr_wmask[0] && csr_wvalue[0];
                    if (!wr && m_zero_tick(j, i, edge_n)) m_pend[j][i] = 1'b1;
                    else if (cl) m_pend[j][i] = 1'b0;
                    if (wr) begin
                        nv = (csr_wmask & csr_wvalue) | (~csr_wmask & m_tcfg[j][i]);
                        if (nv[0]) begin
                            m_run[j][i] = 1'b1;
                            m_t0[j][i]  = edge_n;
                        end else begin
                            m_frz[j][i] = m_cnt(j, i, edge_n - 1);
                            m_run[j][i] = 1'b0;
                        end
                        m_tcfg[j][i] = nv;
                    end
                end
            end
        end
        if (!resetn) rst_edge = edge_n;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        bit          h;
        logic [31:0] v;
        logic [NT-1:0] p;
        for (int j = 0; j < 2; j++) begin
            h = 1'b0;
            v = 32'd0;
            for (int i = 0; i < NT; i++) begin
                p[i] = m_pend[j][i];
                if (csr_num == BASE + 14'(4 * i)) begin h = 1'b1; v = m_tcfg[j][i]; end
                if (csr_num == BASE + 14'(4 * i + 1)) begin h = 1'b1; v = 32'(m_cnt(j, i, edge_n)); end
                if (csr_num == BASE + 14'(4 * i + 3)) h = 1'b1;
            end
            chk($sformatf("model inst%0d hit @%0h", j, csr_num), 64'(j == 0 ? hit1 : hit4), 64'(h));
            chk($sformatf("model inst%0d rvalue @%0h", j, csr_num), 64'(j == 0 ? rv1 : rv4), 64'(v));
            chk($sformatf("model inst%0d timer_int", j), 64'(j == 0 ? int1 : int4), 64'(p));
            chk($sformatf("model inst%0d stable_cnt", j), j == 0 ? scnt1 : scnt4, 64'(edge_n - rst_edge));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic wr(logic [13:0] a, logic [31:0] m, logic [31:0] d);
        csr_num = a; csr_we = 1'b1; csr_wmask = m; csr_wvalue = d;
        cyc();
        csr_we = 1'b0;
    endtask

    typedef struct {
        logic [13:0] addr;
        logic        hit;
        logic [31:0] rv;
    } vec_t;
    vec_t tbl [11];

    initial begin
        tbl[0]  = '{14'h041, 1'b1, 32'h0};
        tbl[1]  = '{14'h042, 1'b1, 32'hFFFF_FFFF};
        tbl[2]  = '{14'h043, 1'b0, 32'h0};
        tbl[3]  = '{14'h044, 1'b1, 32'h0};
        tbl[4]  = '{14'h045, 1'b1, 32'h0};
        tbl[5]  = '{14'h046, 1'b1, 32'hFFFF_FFFF};
        tbl[6]  = '{14'h047, 1'b0, 32'h0};
        tbl[7]  = '{14'h048, 1'b1, 32'h0};
        tbl[8]  = '{14'h049, 1'b0, 32'h0};
        tbl[9]  = '{14'h040, 1'b0, 32'h0};
        tbl[10] = '{14'h000, 1'b0, 32'h0};

        // T1: reset values and stable counter start
        resetn = 1'b0;
        cyc();
        cyc();
        csr_num = 14'h042; #1;
        chk("T1 tval0", 64'(rv1), 64'hFFFF_FFFF);
        chk("T1 int", 64'(int1), 64'h0);
        chk("T1 stable0", scnt1, 64'd0);
        resetn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk($sformatf("T1 stable%0d", k), scnt1, 64'(k));
        end

        // Decode table from the post-reset state
        for (int t = 0; t < 11; t++) begin
            csr_num = tbl[t].addr;
            cyc();
            chk($sformatf("tbl hit %0h", tbl[t].addr), 64'(hit1), 64'(tbl[t].hit));
            chk($sformatf("tbl rv %0h", tbl[t].addr), 64'(rv1), 64'(tbl[t].rv));
            chk($sformatf("tbl hit4 %0h", tbl[t].addr), 64'(hit4), 64'(tbl[t].hit));
        end

        // T2: one-shot ch0, initval 2
        wr(14'h041, 32'hFFFF_FFFF, 32'h9);
        csr_num = 14'h042; #1;
        chk("T2 tval start", 64'(rv1), 64'd8);
        for (int v = 7; v >= 0; v--) begin
            cyc();
            chk("T2 tval", 64'(rv1), 64'(v));
            chk("T2 int low", 64'(int1[0]), 64'd0);
        end
        cyc();
        chk("T2 int set", 64'(int1[0]), 64'd1);
        for (int k = 0; k < 20; k++) cyc();
        chk("T2 tval hold", 64'(rv1), 64'hFFFF_FFFF);

        // T3: periodic ch1, initval 1, then clear and re-assert
        wr(14'h045, 32'hFFFF_FFFF, 32'h7);
        csr_num = 14'h046; #1;
        chk("T3 tval start", 64'(rv1), 64'd4);
        for (int v = 3; v >= 0; v--) begin
            cyc();
            chk("T3 tval", 64'(rv1), 64'(v));
        end
        cyc();
        chk("T3 int set", 64'(int1[1]), 64'd1);
        chk("T3 tval reload", 64'(rv1), 64'd4);
        wr(14'h048, 32'h1, 32'h1);
        chk("T3 int cleared", 64'(int1[1]), 64'd0);
        for (int k = 0; k < 3; k++) cyc();
        chk("T3 int still clear", 64'(int1[1]), 64'd0);
        cyc();
        chk("T3 int reasserted", 64'(int1[1]), 64'd1);

        // T4: clear issued on the zero-tick edge loses to the set
        for (int k = 0; k < 4; k++) cyc();
        wr(14'h048, 32'h1, 32'h1);
        chk("T4 collision", 64'(int1[1]), 64'd1);
        wr(14'h048, 32'h1, 32'h1);
        chk("T4 clear after", 64'(int1[1]), 64'd0);

        // T6: freeze via partial write, then reload via partial write
        wr(14'h041, 32'hFFFF_FFFF, 32'h11);
        csr_num = 14'h042;
        for (int k = 0; k < 3; k++) cyc();
        chk("T6 running", 64'(rv1), 64'd13);
        wr(14'h041, 32'h1, 32'h0);
        csr_num = 14'h042;
        for (int k = 0; k < 3; k++) cyc();
        chk("T6 frozen", 64'(rv1), 64'd13);
        csr_num = 14'h041; #1;
        chk("T6 tcfg", 64'(rv1), 64'h10);
        wr(14'h041, 32'h1, 32'h1);
        csr_num = 14'h042; #1;
        chk("T6 reload", 64'(rv1), 64'd16);
        csr_num = 14'h043; #1;
        chk("T6 gap hit", 64'(hit1), 64'd0);
        chk("T6 gap rv", 64'(rv1), 64'd0);

        // T5: PRESCALE=4 instance, each value held 4 cycles
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        wr(14'h041, 32'hFFFF_FFFF, 32'h5);
        csr_num = 14'h042; #1;
        chk("T5 tval start", 64'(rv4), 64'd4);
        for (int k = 1; k < 20; k++) begin
            cyc();
            chk($sformatf("T5 tval k%0d", k), 64'(rv4), 64'(4 - k / 4));
        end
        chk("T5 int low", 64'(int4[0]), 64'd0);
        cyc();
        chk("T5 int set", 64'(int4[0]), 64'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            csr_num = 14'($urandom_range(32'h040, 32'h049));
            if ($urandom_range(0, 19) == 0) csr_num = 14'($urandom);
            csr_we = ($urandom_range(0, 5) == 0);
            csr_wmask = ($urandom_range(0, 2) == 0) ? $urandom : 32'hFFFF_FFFF;
            if (csr_num == BASE || csr_num == BASE + 14'd4)
                csr_wvalue = 32'($urandom_range(0, 47));
            else
                csr_wvalue = $urandom;
            resetn = ($urandom_range(0, 599) != 0);
            cyc();
        end
        csr_we = 1'b0;
        resetn = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
